// File: rtl/wide_add_seq_if.sv
// Operand/result bundle for wide_add_seq: start/sub/operands in, status and result out.
interface wide_add_seq_if #(
  parameter int WORDS = 4
);
  localparam int W = 16 * WORDS;

  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         c_out;
  logic         overflow;

  modport master (output start, sub, a, b,
                  input  busy, done, sum, c_out, overflow);
  modport slave  (input  start, sub, a, b,
                  output busy, done, sum, c_out, overflow);
endinterface

// File: rtl/wide_add_seq.sv
// Multi-precision add/sub: one 16-bit ripple adder reused per word, LS word first,
// carry threaded through a register between words.
module rca16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        ci,
  output logic [15:0] s,
  output logic        co
);
  logic [16:0] c;
  assign c[0] = ci;
  for (genvar i = 0; i < 16; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign co = c[16];
endmodule

module wide_add_seq #(
  parameter int WORDS = 4
) (
  input logic          clk,
  input logic          rst,
  wide_add_seq_if.slave bus
);
  localparam int IW = $clog2(WORDS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]             state;
  logic [IW-1:0]          idx;
  logic                   cy;
  logic [WORDS-1:0][15:0] a_reg, b_reg, sum_r;
  logic                   c_out_r, ov_r;

  logic [15:0] a_w, b_w, s_w;
  logic        co_w, last;

  // b_reg already holds ~b for subtract, so a_w/b_w feed the adder directly
  assign a_w  = a_reg[idx];
  assign b_w  = b_reg[idx];
  assign last = (idx == IW'(WORDS - 1));

  rca16 u_add (.a(a_w), .b(b_w), .ci(cy), .s(s_w), .co(co_w));

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      idx     <= '0;
      cy      <= 1'b0;
      a_reg   <= '0;
      b_reg   <= '0;
      sum_r   <= '0;
      c_out_r <= 1'b0;
      ov_r    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (bus.start) begin
          a_reg <= bus.a;
          b_reg <= bus.sub ? ~bus.b : bus.b;
          cy    <= bus.sub;
          idx   <= '0;
          sum_r <= '0;
          state <= S_RUN;
        end
        S_RUN: begin
          sum_r[idx] <= s_w;
          cy         <= co_w;
          idx        <= idx + 1'b1;
          if (last) begin
            c_out_r <= co_w;
            ov_r    <= (a_w[15] ^ s_w[15]) & (b_w[15] ^ s_w[15]);
            state   <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy     = (state != S_IDLE);
  assign bus.done     = (state == S_DONE);
  assign bus.sum      = sum_r;
  assign bus.c_out    = c_out_r;
  assign bus.overflow = ov_r;
endmodule

// File: tb/tb_wide_add_seq.sv
// Directed vectors and protocol sequences on WORDS=4, random sweep on WORDS=2 and 16.
module tb_wide_add_seq;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wide_add_seq_if #(.WORDS(4))  if4 ();
  wide_add_seq_if #(.WORDS(2))  if2 ();
  wide_add_seq_if #(.WORDS(16)) if16 ();

  wide_add_seq #(.WORDS(4))  dut4  (.clk(clk), .rst(rst), .bus(if4));
  wide_add_seq #(.WORDS(2))  dut2  (.clk(clk), .rst(rst), .bus(if2));
  wide_add_seq #(.WORDS(16)) dut16 (.clk(clk), .rst(rst), .bus(if16));

  typedef struct {
    logic [63:0] a, b;
    logic        sub;
    logic [63:0] sum;
    logic        c, ov;
  } vec_t;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts in the current (idle) cycle, returns in cycle 6 (idle again).
  task automatic op4(input logic [63:0] a, input logic [63:0] b, input logic sub,
                     output logic [63:0] s, output logic c, output logic ov, output logic tim_ok);
    if4.start = 1'b1; if4.sub = sub; if4.a = a; if4.b = b;
    tick();
    if4.start = 1'b0;
    tim_ok = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      if (if4.busy !== 1'b1 || if4.done !== (k == 5)) tim_ok = 1'b0;
      if (k < 5) tick();
    end
    s = if4.sum; c = if4.c_out; ov = if4.overflow;
    tick();
    if (if4.busy !== 1'b0 || if4.done !== 1'b0) tim_ok = 1'b0;
  endtask

  task automatic drv(input int words, input logic st, input logic sb,
                     input logic [255:0] a, input logic [255:0] b);
    if (words == 2) begin
      if2.start = st; if2.sub = sb; if2.a = a[31:0]; if2.b = b[31:0];
    end else begin
      if16.start = st; if16.sub = sb; if16.a = a; if16.b = b;
    end
  endtask

  task automatic sweep(input int words, input int n);
    int w;
    logic [256:0] mask, full;
    logic [255:0] a, b, bb, es, gs;
    logic sub, ec, eov, gc, gov, d;
    int dc, nd;
    w = 16 * words;
    mask = (257'd1 << w) - 257'd1;
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 8; k++) begin
        a[k*32 +: 32] = $urandom();
        b[k*32 +: 32] = $urandom();
      end
      sub = 1'($urandom_range(0, 1));
      case (i % 8)
        0: a = mask[255:0];
        1: b = mask[255:0];
        2: a = 256'd1 << (w - 1);
        3: b = '0;
        default: ;
      endcase
      a = a & mask[255:0];
      b = b & mask[255:0];
      bb   = sub ? (~b & mask[255:0]) : b;
      full = {1'b0, a} + {1'b0, bb} + 257'(sub);
      es   = full[255:0] & mask[255:0];
      ec   = full[w];
      if (!sub) eov = (a[w-1] == b[w-1]) && (es[w-1] != a[w-1]);
      else      eov = (a[w-1] != b[w-1]) && (es[w-1] != a[w-1]);

      drv(words, 1'b1, sub, a, b);
      tick();
      drv(words, 1'b0, 1'b0, '0, '0);
      dc = 0; nd = 0; gs = '0; gc = 1'b0; gov = 1'b0;
      for (int k = 1; k <= words + 2; k++) begin
        d = (words == 2) ? if2.done : if16.done;
        if (d === 1'b1) begin
          nd++;
          if (dc == 0) begin
            dc  = k;
            gs  = (words == 2) ? {224'b0, if2.sum} : if16.sum;
            gc  = (words == 2) ? if2.c_out : if16.c_out;
            gov = (words == 2) ? if2.overflow : if16.overflow;
          end
        end
        if (k < words + 2) tick();
      end
      n_chk++;
      if (nd == 1 && dc == words + 1 && gs === es && gc === ec && gov === eov) n_pass++;
      else $display("FAIL sweep W%0d op%0d: got sum=%0h c=%0b ov=%0b done@%0d(n=%0d) want sum=%0h c=%0b ov=%0b done@%0d",
                    words, i, gs, gc, gov, dc, nd, es, ec, eov, words + 1);
    end
  endtask

  initial begin
    vec_t vt[8];
    logic [63:0] s;
    logic c, ov, tim;
    int dc;

    vt[0] = '{64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0};
    vt[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h0,                   1'b1, 1'b0};
    vt[2] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
    vt[3] = '{64'd7,                   64'd5, 1'b1, 64'd2,                   1'b1, 1'b0};
    vt[4] = '{64'd5,                   64'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
    vt[5] = '{64'h8000_0000_0000_0000, 64'd1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
    vt[6] = '{64'd0,                   64'd0, 1'b1, 64'd0,                   1'b1, 1'b0};
    vt[7] = '{64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0,
              64'h2222_2222_2222_2211, 1'b0, 1'b0};

    rst = 1'b1;
    if4.start = 1'b0; if4.sub = 1'b0; if4.a = '0; if4.b = '0;
    drv(2, 1'b0, 1'b0, '0, '0);
    drv(16, 1'b0, 1'b0, '0, '0);
    tick(); tick();
    chk("rst_busy", if4.busy, 0);
    chk("rst_done", if4.done, 0);
    chk("rst_sum",  if4.sum, 0);
    chk("rst_cout", if4.c_out, 0);
    chk("rst_ovf",  if4.overflow, 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) begin
      op4(vt[i].a, vt[i].b, vt[i].sub, s, c, ov, tim);
      chk($sformatf("vec%0d_sum", i),  s,   vt[i].sum);
      chk($sformatf("vec%0d_cout", i), c,   vt[i].c);
      chk($sformatf("vec%0d_ovf", i),  ov,  vt[i].ov);
      chk($sformatf("vec%0d_timing", i), tim, 1);
    end

    // start held high, operands scrambled during RUN; re-accept in cycle 6
    if4.start = 1'b1; if4.sub = 1'b0; if4.a = 64'd1; if4.b = 64'd2;
    tick();
    for (int k = 1; k <= 5; k++) begin
      if (k == 5) begin
        chk("hold_done5", if4.done, 1);
        chk("hold_sum",   if4.sum, 3);
      end
      if4.a = {$urandom(), $urandom()};
      if4.b = {$urandom(), $urandom()};
      if4.sub = 1'($urandom_range(0, 1));
      tick();
    end
    chk("hold_idle6", if4.busy, 0);
    if4.a = 64'd10; if4.b = 64'd20; if4.sub = 1'b0;
    tick();
    chk("hold_busy7", if4.busy, 1);
    if4.start = 1'b0;
    repeat (4) tick();
    chk("hold2_done11", if4.done, 1);
    chk("hold2_sum",    if4.sum, 30);
    tick();

    // start pulsed only during DONE must be dropped
    if4.start = 1'b1; if4.sub = 1'b0; if4.a = 64'd100; if4.b = 64'd23;
    tick();
    if4.start = 1'b0;
    repeat (4) tick();
    chk("ign_done5", if4.done, 1);
    if4.start = 1'b1; if4.a = 64'd5; if4.b = 64'd5;
    tick();
    if4.start = 1'b0;
    chk("ign_busy6", if4.busy, 0);
    tick();
    chk("ign_busy7", if4.busy, 0);
    chk("ign_sum",   if4.sum, 123);

    // reset mid-RUN, with start asserted alongside it
    op4(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, s, c, ov, tim);
    chk("pre_rst_cout", c, 1);
    if4.start = 1'b1; if4.a = 64'h0001_0001_0001_0001; if4.b = 64'h0001_0001_0001_0001;
    tick();
    if4.start = 1'b0;
    tick();
    rst = 1'b1; if4.start = 1'b1; if4.a = 64'd5; if4.b = 64'd5;
    tick();
    rst = 1'b0; if4.start = 1'b0;
    chk("mrst_busy", if4.busy, 0);
    chk("mrst_done", if4.done, 0);
    chk("mrst_sum",  if4.sum, 0);
    chk("mrst_cout", if4.c_out, 0);
    tick();
    if4.start = 1'b1; if4.sub = 1'b0; if4.a = 64'd1; if4.b = 64'd1;
    tick();
    if4.start = 1'b0;
    dc = 0; s = '0;
    for (int k = 5; k <= 12; k++) begin
      if (dc == 0 && if4.done === 1'b1) begin dc = k; s = if4.sum; end
      tick();
    end
    chk("mrst_done_cycle", dc, 9);
    chk("mrst_sum2", s, 2);

    sweep(2, 1000);
    sweep(16, 1000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
